pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined add/subtract unit with optional signed saturation and a valid/ready handshake. It is the multi-cycle successor to the single-cycle `adder` primitive. The `WIDTH`-bit operation is split into `STAGES` carry-chained chunks, one chunk per pipeline stage, so wide adds (64/128-bit FPU and crypto datapaths) meet timing at full throughput. It is placed between a producer and a consumer that both speak valid/ready.

## Interface
- `WIDTH`, 64: operand/result width; must be divisible by `STAGES`.
- `STAGES`, 4: pipeline depth and chunk count, ≥1; chunk width `CW = WIDTH/STAGES`.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset_n` input 1: reset, asynchronous, active-low; clears all state immediately when low.
- `A` input WIDTH: operand A.
- `B` input WIDTH: operand B.
- `Op` input 2: operation:
  - 00 = A+B
  - 01 = A−B
  - 10 = A+B signed-saturating
  - 11 = A−B signed-saturating
- `InValid` input 1: A/B/Op valid.
- `InReady` output 1: unit can accept this cycle.
- `Y` output WIDTH: result.
- `Cout` output 1: carry out of MSB. For subtraction, 1 = no borrow (A ≥ B unsigned).
- `Overflow` output 1: two's-complement signed overflow of the unsaturated result.
- `OutValid` output 1: Y/Cout/Overflow valid.
- `OutReady` input 1: consumer accepts this cycle.

## Operation
- Subtraction is A + ~B + 1. The +1 enters as carry-in to chunk 0. Bit 0 of `Op` selects the inversion of B at acceptance.
- Stage k (0..STAGES−1) adds chunk k, bits [k·CW +: CW], of A and the conditioned B. Its carry-in is the carry registered by stage k−1, or Op[0] for k=0.
- Each stage register holds:
  - result chunks 0..k;
  - unprocessed upper chunks of A and the conditioned B;
  - the carry out of chunk k;
  - carry into the MSB (final stage only);
  - Op;
  - a valid bit.
- Final stage computes:
  - `Cout` = carry out of bit WIDTH−1;
  - `Overflow` = carry into MSB XOR carry out of MSB.
- Saturation (Op[1]=1) is applied in the final stage, when Overflow=1:
  - `Y` = 0111…1 if A[WIDTH−1]=0;
  - `Y` = 1000…0 if A[WIDTH−1]=1.
  - `Overflow` and `Cout` still report the unsaturated values.
- Op[1]=0: `Y` is the modulo-2^WIDTH result; no saturation.
- Stall control is a single global advance: `Adv = ~OutValid | OutReady`.
  - `InReady = Adv`.
  - All stage registers, including the output register, load only when Adv=1.
  - A stage with valid=0 still loads, so bubbles propagate.
- Transfer in happens when InValid & InReady. When Adv=1 and InValid=0, a bubble (valid=0) enters stage 0.
- Transfer out happens when OutValid & OutReady.
- Outputs are held stable while OutValid & ~OutReady. Data registers of invalid stages are don't-care, but the output register is only updated by a valid item.
- No reordering or dropping: items leave in acceptance order, one per transfer.
- STAGES=1 degenerates to one registered full-width add/sub with the same handshake.

## Timing
- Reset (reset_n low, asynchronous): all valid bits 0, `OutValid`=0, `Y`=0, `Cout`=0, `Overflow`=0. In-flight items are discarded.
- `InReady` is combinational from `OutValid`/`OutReady` only. There is no combinational path from `InValid`, `A`, `B` or `Op` to any output.
- Latency: an item accepted at edge t appears with `OutValid`=1 after edge t+STAGES−1 if never stalled. Each stalled cycle adds one.
- Throughput: one item per cycle while `OutReady`=1.
- Full pipeline with `OutReady`=0: `InReady`=0, and the state is frozen indefinitely.
- A simultaneous transfer out and transfer in in the same cycle is legal and sustains full rate.
- Carry across chunks: a carry out of chunk k is consumed by chunk k+1 exactly one advance later, never earlier and never lost across stalls.
- Deasserting reset_n mid-stream clears the pipeline. The first item accepted after release emerges with normal latency.

## Test plan
- WIDTH=64, STAGES=4, Op=00, A=0x00000000FFFFFFFF, B=1, OutReady=1 → after 4 edges Y=0x0000000100000000, Cout=0, Overflow=0. This exercises the inter-chunk carry chain.
- Op=01, A=0, B=1 → Y=0xFFFFFFFFFFFFFFFF, Cout=0 (borrow), Overflow=0. Op=01, A=5, B=5 → Y=0, Cout=1.
- Op=10, A=0x7FFFFFFFFFFFFFFF, B=1 → Y=0x7FFFFFFFFFFFFFFF, Overflow=1. Op=11, A=0x8000000000000000, B=1 → Y=0x8000000000000000, Overflow=1. Op=00 with the same first operands → Y=0x8000000000000000, Overflow=1.
- Back-to-back stream of 100 random items with random Op. OutReady toggled randomly → every output matches the reference model in order. No loss or duplication. Y/Cout/Overflow are stable while stalled. InReady=0 exactly when OutValid & ~OutReady.
- Fill the pipeline with OutReady=0 for 10 cycles, then set OutReady=1 → the 4 queued items emerge on consecutive cycles, and InReady rises in the cycle OutReady rises.
- Pull reset_n low asynchronously, mid-clock, with 3 items in flight → OutValid, Y, Cout and Overflow go to 0 immediately. After release, with A=2, B=3, Op=00 → Y=5 after 4 edges, and no stale items appear.

Source files
------------

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined add/subtract with optional signed saturation
// One CW-bit chunk is summed per stage; a single global advance stalls every stage together.
module pipelined_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       Op,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Y,
  output logic             Cout,
  output logic             Overflow,
  output logic             OutValid,
  input  logic             OutReady
);

  localparam int CW = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] a_i  [STAGES];
  logic [WIDTH-1:0] b_i  [STAGES];
  logic [WIDTH-1:0] r_i  [STAGES];
  logic             c_i  [STAGES];
  logic [1:0]       op_i [STAGES];
  logic             v_i  [STAGES];

  assign adv     = ~OutValid | OutReady;
  assign InReady = adv;

  // B is conditioned once at acceptance; the +1 of subtraction enters as chunk 0 carry-in.
  assign a_i[0]  = A;
  assign b_i[0]  = B ^ {WIDTH{Op[0]}};
  assign r_i[0]  = '0;
  assign c_i[0]  = Op[0];
  assign op_i[0] = Op;
  assign v_i[0]  = InValid;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      logic [CW:0]      sum;
      logic [WIDTH-1:0] r_nx;

      assign sum = {1'b0, a_i[k][k*CW +: CW]} + {1'b0, b_i[k][k*CW +: CW]} + {{CW{1'b0}}, c_i[k]};

      always_comb begin
        r_nx = r_i[k];
        r_nx[k*CW +: CW] = sum[CW-1:0];
      end

      if (k < STAGES - 1) begin : g_mid
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] r_q;
        logic             c_q;
        logic [1:0]       op_q;
        logic             v_q;

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            a_q  <= '0;
            b_q  <= '0;
            r_q  <= '0;
            c_q  <= 1'b0;
            op_q <= 2'b00;
            v_q  <= 1'b0;
          end else if (adv) begin
            a_q  <= a_i[k];
            b_q  <= b_i[k];
            r_q  <= r_nx;
            c_q  <= sum[CW];
            op_q <= op_i[k];
            v_q  <= v_i[k];
          end
        end

        assign a_i[k+1]  = a_q;
        assign b_i[k+1]  = b_q;
        assign r_i[k+1]  = r_q;
        assign c_i[k+1]  = c_q;
        assign op_i[k+1] = op_q;
        assign v_i[k+1]  = v_q;
      end else begin : g_last
        logic             c_msb;
        logic             ovf;
        logic [WIDTH-1:0] y_nx;

        // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
        assign c_msb = a_i[k][WIDTH-1] ^ b_i[k][WIDTH-1] ^ sum[CW-1];
        assign ovf   = c_msb ^ sum[CW];

        always_comb begin
          y_nx = r_nx;
          if (op_i[k][1] && ovf) begin
            y_nx = a_i[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
        end

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            OutValid <= 1'b0;
            Y        <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
          end else if (adv) begin
            OutValid <= v_i[k];
            if (v_i[k]) begin
              Y        <= y_nx;
              Cout     <= sum[CW];
              Overflow <= ovf;
            end
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder
// Expected results come from a plain-arithmetic model and an in-order scoreboard queue.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] A, B, Y;
  logic [1:0]  Op;
  logic        InValid, InReady, Cout, Overflow, OutValid, OutReady;

  typedef struct {
    logic [63:0] y;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_acc  = 0;
  int   cyc    = 0;

  pipelined_adder #(.WIDTH(64), .STAGES(4)) dut (
    .clk(clk), .reset_n(reset_n), .A(A), .B(B), .Op(Op),
    .InValid(InValid), .InReady(InReady), .Y(Y), .Cout(Cout),
    .Overflow(Overflow), .OutValid(OutValid), .OutReady(OutReady)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    exp_t        e;
    logic [64:0] full;
    if (op[0]) begin
      e.y = a - b;
      e.c = (a >= b);
      e.o = (a[63] != b[63]) && (e.y[63] != a[63]);
    end else begin
      full = {1'b0, a} + {1'b0, b};
      e.y  = full[63:0];
      e.c  = full[64];
      e.o  = (a[63] == b[63]) && (e.y[63] != a[63]);
    end
    if (op[1] && e.o) e.y = a[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    return e;
  endfunction

  function automatic logic [63:0] rnd_operand();
    case ($urandom % 5)
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'h7FFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000 | 64'($urandom % 4);
      3:       return 64'($urandom % 8);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One cycle, entered and left at a falling edge.
  task automatic step(input logic iv, input logic [63:0] a, input logic [63:0] b,
                      input logic [1:0] op, input logic ordy);
    logic        acc, oxfer, stall, c0, o0;
    logic [63:0] y0;
    exp_t        e;
    InValid = iv; A = a; B = b; Op = op; OutReady = ordy;
    #1;
    check("in_ready", InReady, !(OutValid && !ordy));
    acc   = iv && InReady;
    oxfer = OutValid && ordy;
    stall = OutValid && !ordy;
    y0 = Y; c0 = Cout; o0 = Overflow;
    if (oxfer) begin
      if (sb.size() == 0) begin
        check("unexpected_out", OutValid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("out_y", Y, e.y);
        check("out_cout", Cout, e.c);
        check("out_ovf", Overflow, e.o);
      end
    end
    @(posedge clk);
    cyc++;
    if (acc) begin
      sb.push_back(model(a, b, op));
      n_acc++;
    end
    #1;
    if (stall) begin
      check("stall_valid", OutValid, 1'b1);
      check("stall_y", Y, y0);
      check("stall_cout", Cout, c0);
      check("stall_ovf", Overflow, o0);
    end
    @(negedge clk);
  endtask

  task automatic run_one(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] op, input logic [63:0] ey, input logic ec, input logic eo);
    step(1'b1, a, b, op, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_early"}, OutValid, 1'b0);
      step(1'b0, '0, '0, 2'b00, 1'b1);
    end
    check({tag, "_valid"}, OutValid, 1'b1);
    check({tag, "_y"}, Y, ey);
    check({tag, "_cout"}, Cout, ec);
    check({tag, "_ovf"}, Overflow, eo);
    step(1'b0, '0, '0, 2'b00, 1'b1);
  endtask

  initial begin
    int start_acc;
    int target;
    reset_n = 1'b0; InValid = 1'b0; A = '0; B = '0; Op = 2'b00; OutReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", OutValid, 1'b0);
    check("rst_y", Y, 64'h0);
    check("rst_cout", Cout, 1'b0);
    check("rst_ovf", Overflow, 1'b0);
    check("rst_in_ready", InReady, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);

    run_one("carry_chain", 64'h0000_0000_FFFF_FFFF, 64'h1, 2'b00, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
    run_one("sub_borrow", 64'h0, 64'h1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_one("sub_equal", 64'h5, 64'h5, 2'b01, 64'h0, 1'b1, 1'b0);
    run_one("sat_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    run_one("sat_sub", 64'h8000_0000_0000_0000, 64'h1, 2'b11, 64'h8000_0000_0000_0000, 1'b1, 1'b1);
    run_one("wrap_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // Fill with the consumer stalled, then release.
    start_acc = n_acc;
    for (int i = 0; i < 10; i++) step(1'b1, rnd_operand(), rnd_operand(), 2'($urandom), 1'b0);
    check("fill_accepted", 64'(n_acc - start_acc), 64'd4);
    check("fill_in_ready", InReady, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("burst_valid", OutValid, 1'b1);
      step(1'b0, '0, '0, 2'b00, 1'b1);
    end
    check("burst_done", OutValid, 1'b0);
    check("burst_sb_empty", 64'(sb.size()), 64'd0);

    // Random stream with random backpressure.
    start_acc = n_acc;
    target    = n_acc + 100;
    cyc       = 0;
    while (n_acc < target && cyc < 3000)
      step(1'b1, rnd_operand(), rnd_operand(), 2'($urandom), 1'($urandom % 3 != 0));
    while (sb.size() > 0 && cyc < 3200)
      step(1'b0, '0, '0, 2'b00, 1'($urandom % 2));
    check("stream_accepted", 64'(n_acc - start_acc), 64'd100);
    check("stream_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset with three items in flight.
    step(1'b1, 64'h2, 64'h3, 2'b00, 1'b0);
    step(1'b1, rnd_operand(), rnd_operand(), 2'($urandom), 1'b0);
    step(1'b1, rnd_operand(), rnd_operand(), 2'($urandom), 1'b0);
    step(1'b0, '0, '0, 2'b00, 1'b0);
    check("pre_reset_valid", OutValid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_valid", OutValid, 1'b0);
    check("async_y", Y, 64'h0);
    check("async_cout", Cout, 1'b0);
    check("async_ovf", Overflow, 1'b0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    run_one("post_reset", 64'h2, 64'h3, 2'b00, 64'h5, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 2'b00, 1'b1);
    check("no_stale", OutValid, 1'b0);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
